// File: rtl/bch_decoder_15_7.sv
// BCH(15,7,t=2) decoder over GF(16) (x^4+x+1): serial syndromes, closed-form key
// equation, serial Chien search. Fixed 32-cycle latency with a valid/ready handshake on each side.
module bch_decoder_15_7 #(
  parameter bit FAIL_PASSTHRU = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [14:0] in_codeword,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [6:0]  out_data,
  output logic [14:0] out_corrected,
  output logic [1:0]  out_nerr,
  output logic        out_fail
);

  localparam int unsigned N = 15;
  localparam int unsigned M = 4;

  typedef enum logic [2:0] {IDLE, SYND, KEY, CHIEN, OUT} state_t;

  state_t       state, state_nx;
  logic [N-1:0] raw, word;
  logic [3:0]   cnt;
  logic [M-1:0] s1, s3, t1, t2;
  logic [1:0]   nexp, roots;
  logic         key_fail;

  // Polynomial-basis GF(16) multiply, reduced by x^4 = x + 1
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[2:0], 1'b0} ^ (x[3] ? 4'b0011 : 4'b0000);
    end
    return p;
  endfunction

  function automatic logic [M-1:0] gf_inv(input logic [M-1:0] a);
    case (a)
      4'h1: gf_inv = 4'h1;  4'h2: gf_inv = 4'h9;  4'h3: gf_inv = 4'hE;  4'h4: gf_inv = 4'hD;
      4'h5: gf_inv = 4'hB;  4'h6: gf_inv = 4'h7;  4'h7: gf_inv = 4'h6;  4'h8: gf_inv = 4'hF;
      4'h9: gf_inv = 4'h2;  4'hA: gf_inv = 4'hC;  4'hB: gf_inv = 4'h5;  4'hC: gf_inv = 4'hA;
      4'hD: gf_inv = 4'h4;  4'hE: gf_inv = 4'h3;  4'hF: gf_inv = 4'h8;  default: gf_inv = 4'h0;
    endcase
  endfunction

  logic [3:0]   bit_idx;
  logic         r_bit;
  logic [M-1:0] s1_cube, sigma2;
  logic         hit, last;
  logic [1:0]   roots_nx;
  logic [N-1:0] word_nx, result;
  logic         final_fail;

  // Datapath combinational helpers
  always_comb begin
    bit_idx    = 4'(4'd14 - cnt);
    r_bit      = raw[bit_idx];
    s1_cube    = gf_mul(gf_mul(s1, s1), s1);
    sigma2     = gf_mul(s3 ^ s1_cube, gf_inv(s1));
    hit        = ((4'h1 ^ t1 ^ t2) == 4'h0);
    last       = (cnt == 4'd14);
    roots_nx   = 2'(roots + 2'(hit));
    word_nx    = word ^ (N'(hit) << cnt);
    final_fail = key_fail || (roots_nx != nexp);
    if (!final_fail)        result = word_nx;
    else if (FAIL_PASSTHRU) result = raw;
    else                    result = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid && in_ready) state_nx = SYND;
      SYND:    if (last) state_nx = KEY;
      KEY:     state_nx = CHIEN;
      CHIEN:   if (last) state_nx = OUT;
      OUT:     if (out_valid && out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // out_valid follows one cycle into OUT so results settle before being offered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_corrected <= '0;
      out_nerr      <= '0;
      out_fail      <= 1'b0;
      raw           <= '0;
      word          <= '0;
      cnt           <= '0;
      s1            <= '0;
      s3            <= '0;
      t1            <= '0;
      t2            <= '0;
      nexp          <= '0;
      roots         <= '0;
      key_fail      <= 1'b0;
    end else begin
      in_ready  <= (state_nx == IDLE);
      out_valid <= (state == OUT) && (state_nx == OUT);
      case (state)
        IDLE: if (in_valid && in_ready) begin
          raw      <= in_codeword;
          word     <= in_codeword;
          cnt      <= '0;
          s1       <= '0;
          s3       <= '0;
          roots    <= '0;
          key_fail <= 1'b0;
        end
        SYND: begin
          s1  <= gf_mul(s1, 4'h2) ^ M'(r_bit);
          s3  <= gf_mul(s3, 4'h8) ^ M'(r_bit);
          cnt <= last ? 4'd0 : 4'(cnt + 4'd1);
        end
        KEY: begin
          cnt <= '0;
          t1  <= s1;
          if (s1 == 4'h0) begin
            t2       <= '0;
            nexp     <= 2'd0;
            key_fail <= (s3 != 4'h0);
          end else if (s3 == s1_cube) begin
            t2   <= '0;
            nexp <= 2'd1;
          end else begin
            t2   <= sigma2;
            nexp <= 2'd2;
          end
        end
        CHIEN: begin
          word  <= word_nx;
          roots <= roots_nx;
          t1    <= gf_mul(t1, 4'h9);
          t2    <= gf_mul(t2, 4'hD);
          cnt   <= last ? 4'd0 : 4'(cnt + 4'd1);
          if (last) begin
            out_corrected <= result;
            out_data      <= result[14:8];
            out_nerr      <= final_fail ? 2'd0 : roots_nx;
            out_fail      <= final_fail;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/bch_decoder_15_7.md
BCH_DECODER_15_7 -- requirements
Module: bch_decoder_15_7

Interface
REQ-001 The block SHALL have parameter FAIL_PASSTHRU, default 1: when 1, an uncorrectable word outputs the raw received bits; when 0, it outputs all-zero bits.
REQ-002 The block SHALL have port clk, input, 1 bit: clock; all logic rises on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the codeword on in_codeword is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the decoder can accept a codeword.
REQ-006 The block SHALL have port in_codeword, input, 15 bits: received word r(x) = sum of in_codeword[i]·x^i, with message in [14:8] and parity in [7:0].
REQ-007 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-008 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-009 The block SHALL have port out_data, output, 7 bits: corrected message (corrected word bits [14:8]).
REQ-010 The block SHALL have port out_corrected, output, 15 bits: full corrected codeword.
REQ-011 The block SHALL have port out_nerr, output, 2 bits: number of corrected errors (0, 1 or 2).
REQ-012 The block SHALL have port out_fail, output, 1 bit: the word was uncorrectable.

Function
REQ-013 The block SHALL decode the narrow-sense binary BCH(15,7,t=2) code over GF(16) with primitive polynomial x^4+x+1 (alpha^4 = 4'b0011) and generator g(x) = x^8+x^7+x^6+x^4+1 (15'h01D1).
REQ-014 The FSM SHALL have states IDLE, SYND, KEY, CHIEN and OUT; in_ready = 1 only in IDLE, and out_valid = 1 only in OUT.
REQ-015 IDLE SHALL go to SYND on in_valid && in_ready, registering in_codeword.
REQ-016 SYND SHALL run for exactly 15 cycles, consuming bits 14 down to 0 MSB-first by Horner's rule: S1 <= S1·alpha + r_i and S3 <= S3·alpha^3 + r_i, with both starting at 0.
REQ-017 KEY SHALL take one cycle and compute the error-locator polynomial and the expected error count:
- S1 = 0 and S3 = 0: no error, nexp = 0.
- S1 = 0 and S3 ≠ 0: fail.
- S1 ≠ 0 and S3 = S1^3: sigma1 = S1, sigma2 = 0, nexp = 1.
- Otherwise: sigma1 = S1, sigma2 = (S3 + S1^3)·S1^-1 (inverse from a 16-entry LUT), nexp = 2.
REQ-018 CHIEN SHALL run for exactly 15 cycles (i = 0..14), flipping bit i when 1 + sigma1·alpha^-i + sigma2·alpha^-2i = 0, and counting the roots found.
REQ-019 At the end of CHIEN, if roots ≠ nexp or the KEY step failed, the block SHALL set out_fail = 1 and out_nerr = 0, and drive out_corrected with the raw word (or with 0 when FAIL_PASSTHRU = 0).
REQ-020 Latency SHALL be fixed regardless of error count: out_valid rises on the 32nd rising edge after the accepting edge.
REQ-021 In OUT, all outputs SHALL hold stable while out_ready = 0; the handshake out_valid && out_ready SHALL return the FSM to IDLE, so in_ready rises in the next cycle (no input/output overlap, throughput one word per 33 or more cycles).
REQ-022 in_valid asserted outside IDLE SHALL be ignored.
REQ-023 All GF(16) multiplies SHALL be combinational within one cycle, and no division other than the LUT inverse SHALL be used.

Reset
REQ-024 While rst = 1: state = IDLE, in_ready = 1, out_valid = 0, out_data = 0, out_corrected = 0, out_nerr = 0, out_fail = 0, and syndrome/locator/counter registers are cleared.
REQ-025 Reset asserted mid-SYND, mid-CHIEN or in OUT SHALL abort the word, which is never output; after release, the next accepted word decodes correctly.

Verification
REQ-026 Clean word 15'h01D1 -> out_data = 7'h01, out_corrected = 15'h01D1, out_nerr = 0, out_fail = 0, out_valid 32 edges after accept.
REQ-027 Single error 15'h41D1 (bit 14 flipped) -> out_data = 7'h01, out_corrected = 15'h01D1, out_nerr = 1, out_fail = 0.
REQ-028 Double error 15'h03D0 (bits 0 and 9 flipped) -> out_data = 7'h01, out_corrected = 15'h01D1, out_nerr = 2, out_fail = 0.
REQ-029 Word 15'h0421 (bits 0, 5, 10 set on an all-zero codeword; S1 = 0, S3 = 1) -> out_fail = 1, out_nerr = 0, out_data = 7'h04 with FAIL_PASSTHRU = 1 and 7'h00 with FAIL_PASSTHRU = 0.
REQ-030 out_ready held at 0 for 5 cycles in OUT -> outputs stable, in_ready = 0, second in_valid ignored; on out_ready = 1 -> IDLE, and the next word is accepted.
REQ-031 rst pulse during CHIEN -> all outputs at reset values, no out_valid; then 15'h41D1 -> out_data = 7'h01, out_nerr = 1.
